// File: rtl/registered_demultiplexer_mxn.sv
// One-to-M registered demultiplexer: each output channel holds one word behind a
// valid/ready handshake; out-of-range selects are swallowed and flagged in sel_err.
module registered_demultiplexer_mxn #(
  parameter  int unsigned M     = 8,
  parameter  int unsigned N     = 5,
  localparam int unsigned SEL_W = $clog2(M)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SEL_W-1:0] select,
  input  logic [N-1:0]     i,
  input  logic             enabler,
  output logic             in_ready,
  output logic [M*N-1:0]   o,
  output logic [M-1:0]     o_valid,
  input  logic [M-1:0]     o_ready,
  output logic             busy,
  output logic             sel_err
);

  logic [M-1:0][N-1:0] data_q, data_d;
  logic [M-1:0]        v_q, v_d;
  logic                sel_err_q, sel_err_d;
  logic [M-1:0]        hit;
  logic                in_range;
  logic                accept;

  // One-hot decode of select; an out-of-range select matches no channel, so it
  // never blocks the input and never loads anything.
  always_comb begin
    hit = '0;
    for (int unsigned k = 0; k < M; k++) begin
      hit[k] = (select == SEL_W'(k));
    end
  end

  assign in_range = |hit;
  assign in_ready = ~|(hit & v_q & ~o_ready);
  assign accept   = enabler && in_ready;

  always_comb begin
    data_d    = data_q;
    v_d       = v_q;
    sel_err_d = sel_err_q | (enabler && !in_range);
    for (int unsigned k = 0; k < M; k++) begin
      if (accept && hit[k]) begin
        data_d[k] = i;
        v_d[k]    = 1'b1;
      end else if (v_q[k] && o_ready[k]) begin
        data_d[k] = '0;
        v_d[k]    = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q    <= '0;
      v_q       <= '0;
      sel_err_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      v_q       <= v_d;
      sel_err_q <= sel_err_d;
    end
  end

  assign o       = data_q;
  assign o_valid = v_q;
  assign busy    = |v_q;
  assign sel_err = sel_err_q;

endmodule

// File: doc/registered_demultiplexer_mxn.md
# registered_demultiplexer_mxn

One-to-M registered demultiplexer with per-channel valid/ready handshake: routes a single N-bit input word to one of M output channels chosen by a select field. Each channel holds one word until its consumer accepts it. It is the distribution counterpart of the M-to-1 enabled multiplexer and sits in the datapath wherever one producer feeds M selectable consumers, such as register-bank or lane fan-out.

## Interface
- M, default 8, number of output channels (2..32)
- N, default 5, data width per channel
- SEL_W, derived $clog2(M), select width (not overridable)

- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- select  in  SEL_W  destination channel index
- i  in  N  input data word
- enabler  in  1  input valid; word offered this cycle
- in_ready  out  1  input may be accepted this cycle
- o  out  M*N  flattened channel data; channel k at o[k*N +: N] (channel 0 = LSBs)
- o_valid  out  M  per-channel data valid
- o_ready  in  M  per-channel consumer ready
- busy  out  1  OR of o_valid
- sel_err  out  1  sticky: word offered with select >= M

## Operation
- Per channel k: one holding register data_k (N bits) plus valid bit v_k; o[k] = data_k, o_valid[k] = v_k.
- in_ready (combinational) = 1 if select >= M; else !v_sel || o_ready[sel]. It depends on o_ready combinationally, with no registered path in between.
- Accept = enabler && in_ready. On accept with select < M: data_sel <= i, v_sel <= 1 at the next edge.
- Drain of channel k = v_k && o_ready[k]. On a drain with no same-cycle load into k: v_k <= 0, data_k <= 0. Channel outputs read 0 whenever invalid.
- Drain and load of the same channel in the same cycle: data_k <= i, v_k stays 1. No bubble, no loss.
- Drains on other channels proceed independently in the same cycle as a load. Any number of channels may drain simultaneously.
- select >= M (only possible when M is not a power of 2): the word is accepted (in_ready = 1), discarded, and sel_err <= 1. sel_err clears only on rst.
- enabler = 0: no channel is loaded. select and i are don't-care. Drains still occur.
- Data is never overwritten while v_k = 1 unless the same-cycle drain occurs.
- busy = |o_valid, combinational from the registers.

## Timing
- Reset values: o = 0, o_valid = 0, busy = 0, sel_err = 0. in_ready = 1 during and after reset, since all channels are empty.
- rst asserted mid-operation: all pending words are discarded immediately (asynchronous) and sel_err is cleared. The first accept is possible on the first clk edge after rst deasserts.
- Latency: accept at edge t gives o_valid[k] = 1 and valid o[k] after edge t, visible in cycle t+1.
- Throughput: one word per cycle total. A single channel sustains 1 word/cycle while its o_ready is held at 1.
- A full channel with o_ready = 0 stalls the input only when select targets it. A word for a different, empty channel is accepted the same cycle.
- All state changes occur on the rising clk edge, except the asynchronous reset.

## Test plan
- Reset/idle: assert rst mid-run with channels 2 and 5 holding data -> o = 0, o_valid = 8'h00, sel_err = 0 immediately; in_ready = 1 after release.
- Fan-out sweep (M=8, N=5, o_ready = 8'hFF): enabler = 1, select 0..7 over consecutive cycles with i = 5'd1..5'd8 -> channel k shows k+1 with o_valid[k] = 1 one cycle after its accept, then returns to 0.
- Backpressure: o_ready[3] = 0, send 5'h0A then 5'h0B to select = 3 -> first held on o[3], in_ready = 0 on the second. Raise o_ready[3] -> 5'h0B loads on the same edge the drain happens, o_valid[3] stays 1, and o[3] = 5'h0B next cycle.
- Independent channels: channel 3 stalled full, offer 5'h11 to select = 6 -> accepted, o[6] = 5'h11, and channel 3 is unchanged.
- Enabler low: enabler = 0 with select sweeping 0..7 -> o_valid stays 8'h00 and in_ready does not gate anything. Previously loaded channels still drain on o_ready.
- Out-of-range (M=5, SEL_W=3): enabler = 1, select = 3'd6, i = 5'h1F -> in_ready = 1, no o_valid bit set, sel_err = 1 next cycle and remains 1 until rst.
